bypass_rf_operand_reader: RTL and testbench
===========================================

# bypass_rf_operand_reader

Requester-side client for the bypass register file's read-reservation protocol. Per instruction it accepts up to two architectural source addresses, reserves one read slot per operand, polls slot validity until the value is resolved (regfile or forwarded write), captures the data, presents both operands downstream with a valid/ready handshake, then frees the slots. It sits between the decode stage and the execute stage of a pipeline that owns a bypass register file.

## Interface
- addr_width, 5: architectural register address width
- data_width, 32: operand width
- name_width, 1: read-slot name width (matches register file)
- tag_width, 4: opaque instruction tag carried through
- CLK  in  1  clock, rising edge
- RST  in  1  reset, asynchronous, active-low
- REQ_VALID / REQ_READY  in / out  1  upstream handshake
- REQ_ADDR_1, REQ_ADDR_2  in  addr_width  source addresses
- REQ_USE_2  in  1  second operand required
- REQ_TAG  in  tag_width  instruction tag
- ADDR_1, ADDR_2  out  addr_width  reservation address per slot
- RRESE_1, RRESE_2  out  1  reservation request
- RRES_READY_1, RRES_READY_2  in  1  reservation grant
- RNAME_1, RNAME_2  in  name_width  granted slot name
- VALID_NAME_1, VALID_NAME_2  out  name_width  slot being polled
- VALID_IN_1, VALID_IN_2  in  1  slot data resolved
- NAME_1, NAME_2  out  name_width  slot being read (equals VALID_NAME_x)
- D_IN_1, D_IN_2  in  data_width  slot data
- RD_F_1, RD_F_2  out  name_width  slot to free
- FE_1, FE_2  out  1  free enable
- RSP_VALID / RSP_READY  out / in  1  downstream handshake
- RSP_OP_1, RSP_OP_2  out  data_width  operand values
- RSP_TAG  out  tag_width  tag of the instruction in RSP

## Operation
- Two identical operand slots (index x = 1, 2), controlled by one top FSM: IDLE, RESERVE, WAIT, OUT, FREE.
- IDLE: REQ_READY=1. On REQ_VALID, latch addresses, USE_2, and tag; go to RESERVE.
- RESERVE: each active slot drives ADDR_x and RRESE_x=1 until RRES_READY_x is high at an edge, then latches RNAME_x. RRESE_x drops the cycle after the grant. When every active slot is granted, go to WAIT.
- WAIT: each granted slot drives VALID_NAME_x = NAME_x = latched name. On VALID_IN_x=1 at an edge, it latches D_IN_x. When every active slot has captured data, go to OUT.
- OUT: RSP_VALID=1 with stable RSP_OP_1/2 and RSP_TAG until RSP_READY. On handshake, go to FREE.
- FREE: for exactly one cycle, FE_x=1 and RD_F_x=name for each active slot. REQ_READY=1 in this cycle, so a request accepted here goes straight to RESERVE; otherwise go to IDLE.
- REQ_USE_2=0: slot 2 never asserts RRESE_2 or FE_2, counts as granted and captured, and RSP_OP_2=0.
- Slots progress independently within a state. One slot may be granted or captured while the other is still waiting.
- RSP_OP_x holds its value from capture until the next capture.

## Timing
- Reset values (asynchronous, while RST=0): state IDLE, all outputs 0, including REQ_READY. After release, REQ_READY=1 from the first cycle.
- Best case, request accepted at edge 0: RRESE_x high in cycle 1, grant at edge 1, VALID_NAME_x valid in cycle 2, capture at edge 2, RSP_VALID in cycle 3. Latency from acceptance to RSP_VALID is 3 cycles.
- Throughput: one instruction per 4 cycles with no stalls (FREE overlaps the next acceptance).
- The register file allows reserve and free of the same slot in one cycle. The FREE/RESERVE overlap relies on this.
- Reset mid-operation abandons held reservations with no FE. The register file must be reset in the same cycle (system requirement).
- Backpressure: RSP_READY=0 holds OUT indefinitely. Outputs and reservations stay held and FE is not asserted.

## Structure
- Shared package:
  - state enum (IDLE, RESERVE, WAIT, OUT, FREE);
  - slot name type;
  - reset-polarity constant.
- One natural sub-module: operand_slot. It holds name/data/granted/captured registers and drives RRESE/VALID_NAME/FE for one port. It is instantiated twice under the top FSM.

## Test plan
- No-conflict read, register file returns grant and VALID_IN immediately; addr1=3, addr2=7 with data 0x11/0x22 -> RSP_VALID in cycle 3, OP_1=0x11, OP_2=0x22, then FE_1 and FE_2 pulse for one cycle with the granted names.
- Pending write: VALID_IN_1 held low for 5 cycles, then high with 0xDEAD -> RSP_VALID 5 cycles later than best case, OP_1=0xDEAD, RRESE_1 asserted only once.
- RRES_READY_2 low for 3 cycles -> RRESE_2 stays high and ADDR_2 stable for those cycles, slot 1 already granted, RSP waits for slot 2.
- REQ_USE_2=0 -> RRESE_2 and FE_2 never asserted, OP_2=0.
- RSP_READY low for 4 cycles -> OP/TAG stable, no FE. Back-to-back request accepted in the FREE cycle -> RRESE next cycle, 4-cycle period.
- Assert RST in WAIT -> all outputs 0 immediately (asynchronous), no FE. After release, IDLE with REQ_READY=1.

Source files
------------

// File: rtl/bypass_rf_operand_reader_pkg.sv
// Shared FSM encoding, read-slot name type and reset polarity for the bypass-RF operand reader.
package bypass_rf_operand_reader_pkg;

  localparam logic RST_ACTIVE    = 1'b0;
  localparam int   RF_NAME_WIDTH = 1;

  typedef logic [RF_NAME_WIDTH-1:0] slot_name_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RESERVE = 3'd1,
    ST_WAIT    = 3'd2,
    ST_OUT     = 3'd3,
    ST_FREE    = 3'd4
  } state_e;

  // A new instruction may enter while idle or while the previous one frees its slots.
  function automatic logic state_accepts(input state_e s);
    return (s == ST_IDLE) || (s == ST_FREE);
  endfunction

endpackage

// File: rtl/bypass_rf_operand_reader_operand_slot.sv
// One operand port: reserves a read slot, polls it until resolved, captures data, frees it.
// Grant/capture take effect at the edge they are seen; everything is held while the top FSM stalls.
module bypass_rf_operand_reader_operand_slot
  import bypass_rf_operand_reader_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  state_e                i_state,
  input  logic                  i_accept,
  input  logic                  i_use,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic                  o_rrese,
  input  logic                  i_rres_ready,
  input  slot_name_t            i_rname,
  output slot_name_t            o_valid_name,
  input  logic                  i_valid_in,
  input  logic [DATA_WIDTH-1:0] i_d_in,
  output slot_name_t            o_rd_f,
  output logic                  o_fe,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_granted_nxt,
  output logic                  o_captured_nxt
);

  logic                  r_active;
  logic [ADDR_WIDTH-1:0] r_addr;
  slot_name_t            r_name;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_granted;
  logic                  r_captured;

  logic w_grant;
  logic w_capture;

  assign o_rrese   = (i_state == ST_RESERVE) && r_active && !r_granted;
  assign w_grant   = o_rrese && i_rres_ready;
  assign w_capture = (i_state == ST_WAIT) && r_active && !r_captured && i_valid_in;

  assign o_granted_nxt  = r_granted  || w_grant;
  assign o_captured_nxt = r_captured || w_capture;

  assign o_addr       = r_addr;
  assign o_valid_name = ((i_state == ST_WAIT) && r_active) ? r_name : slot_name_t'(0);
  assign o_fe         = (i_state == ST_FREE) && r_active;
  assign o_rd_f       = o_fe ? r_name : slot_name_t'(0);
  assign o_data       = r_data;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (i_rst_n == RST_ACTIVE) begin
      r_active   <= 1'b0;
      r_addr     <= '0;
      r_name     <= '0;
      r_data     <= '0;
      r_granted  <= 1'b0;
      r_captured <= 1'b0;
    end else if (i_accept) begin
      // An unused slot is born granted and captured with a zero operand.
      r_active   <= i_use;
      r_addr     <= i_addr;
      r_granted  <= !i_use;
      r_captured <= !i_use;
      if (!i_use) begin
        r_data <= '0;
      end
    end else begin
      if (w_grant) begin
        r_granted <= 1'b1;
        r_name    <= i_rname;
      end
      if (w_capture) begin
        r_captured <= 1'b1;
        r_data     <= i_d_in;
      end
    end
  end

endmodule

// File: rtl/bypass_rf_operand_reader.sv
// Decode-to-execute operand reader: 3 cycles accept-to-RSP_VALID best case, one instruction per 4 cycles.
// RSP_READY low holds OUT with operands and reservations kept; FREE overlaps the next acceptance.
module bypass_rf_operand_reader
  import bypass_rf_operand_reader_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic [ADDR_WIDTH-1:0] i_req_addr_1,
  input  logic [ADDR_WIDTH-1:0] i_req_addr_2,
  input  logic                  i_req_use_2,
  input  logic [TAG_WIDTH-1:0]  i_req_tag,
  output logic [ADDR_WIDTH-1:0] o_addr_1,
  output logic [ADDR_WIDTH-1:0] o_addr_2,
  output logic                  o_rrese_1,
  output logic                  o_rrese_2,
  input  logic                  i_rres_ready_1,
  input  logic                  i_rres_ready_2,
  input  slot_name_t            i_rname_1,
  input  slot_name_t            i_rname_2,
  output slot_name_t            o_valid_name_1,
  output slot_name_t            o_valid_name_2,
  input  logic                  i_valid_in_1,
  input  logic                  i_valid_in_2,
  output slot_name_t            o_name_1,
  output slot_name_t            o_name_2,
  input  logic [DATA_WIDTH-1:0] i_d_in_1,
  input  logic [DATA_WIDTH-1:0] i_d_in_2,
  output slot_name_t            o_rd_f_1,
  output slot_name_t            o_rd_f_2,
  output logic                  o_fe_1,
  output logic                  o_fe_2,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [DATA_WIDTH-1:0] o_rsp_op_1,
  output logic [DATA_WIDTH-1:0] o_rsp_op_2,
  output logic [TAG_WIDTH-1:0]  o_rsp_tag
);

  state_e               r_state;
  state_e               w_next_state;
  logic                 r_ready_en;
  logic [TAG_WIDTH-1:0] r_tag;

  logic w_req_ready;
  logic w_accept;
  logic w_granted_1;
  logic w_granted_2;
  logic w_captured_1;
  logic w_captured_2;
  logic w_all_granted;
  logic w_all_captured;

  // r_ready_en keeps REQ_READY low while reset is asserted even though the FSM sits in IDLE.
  assign w_req_ready    = r_ready_en && state_accepts(r_state);
  assign w_accept       = i_req_valid && w_req_ready;
  assign w_all_granted  = w_granted_1 && w_granted_2;
  assign w_all_captured = w_captured_1 && w_captured_2;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (i_rst_n == RST_ACTIVE) begin
      r_state    <= ST_IDLE;
      r_ready_en <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_ready_en <= 1'b1;
    end
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE:    if (w_accept)       w_next_state = ST_RESERVE;
      ST_RESERVE: if (w_all_granted)  w_next_state = ST_WAIT;
      ST_WAIT:    if (w_all_captured) w_next_state = ST_OUT;
      ST_OUT:     if (i_rsp_ready)    w_next_state = ST_FREE;
      ST_FREE:    w_next_state = w_accept ? ST_RESERVE : ST_IDLE;
      default:    w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    o_req_ready = w_req_ready;
    o_rsp_valid = (r_state == ST_OUT);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (i_rst_n == RST_ACTIVE) begin
      r_tag <= '0;
    end else if (w_accept) begin
      r_tag <= i_req_tag;
    end
  end

  assign o_rsp_tag = r_tag;
  assign o_name_1  = o_valid_name_1;
  assign o_name_2  = o_valid_name_2;

  bypass_rf_operand_reader_operand_slot #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_slot_1 (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_state        (r_state),
    .i_accept       (w_accept),
    .i_use          (1'b1),
    .i_addr         (i_req_addr_1),
    .o_addr         (o_addr_1),
    .o_rrese        (o_rrese_1),
    .i_rres_ready   (i_rres_ready_1),
    .i_rname        (i_rname_1),
    .o_valid_name   (o_valid_name_1),
    .i_valid_in     (i_valid_in_1),
    .i_d_in         (i_d_in_1),
    .o_rd_f         (o_rd_f_1),
    .o_fe           (o_fe_1),
    .o_data         (o_rsp_op_1),
    .o_granted_nxt  (w_granted_1),
    .o_captured_nxt (w_captured_1)
  );

  bypass_rf_operand_reader_operand_slot #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_slot_2 (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_state        (r_state),
    .i_accept       (w_accept),
    .i_use          (i_req_use_2),
    .i_addr         (i_req_addr_2),
    .o_addr         (o_addr_2),
    .o_rrese        (o_rrese_2),
    .i_rres_ready   (i_rres_ready_2),
    .i_rname        (i_rname_2),
    .o_valid_name   (o_valid_name_2),
    .i_valid_in     (i_valid_in_2),
    .i_d_in         (i_d_in_2),
    .o_rd_f         (o_rd_f_2),
    .o_fe           (o_fe_2),
    .o_data         (o_rsp_op_2),
    .o_granted_nxt  (w_granted_2),
    .o_captured_nxt (w_captured_2)
  );

endmodule

// File: tb/tb_bypass_rf_operand_reader.sv
// Randomized bench: acts as decode stage, register file and execute stage around the operand reader.
module tb_bypass_rf_operand_reader;
  import bypass_rf_operand_reader_pkg::*;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int TW = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          req_valid, req_ready, req_use_2;
  logic [AW-1:0] req_addr_1, req_addr_2, o_addr_1, o_addr_2;
  logic [TW-1:0] req_tag, rsp_tag;
  logic          o_rrese_1, o_rrese_2, rres_ready_1, rres_ready_2;
  slot_name_t    rname_1, rname_2, o_valid_name_1, o_valid_name_2, o_name_1, o_name_2;
  slot_name_t    o_rd_f_1, o_rd_f_2;
  logic          valid_in_1, valid_in_2, o_fe_1, o_fe_2;
  logic [DW-1:0] d_in_1, d_in_2, rsp_op_1, rsp_op_2;
  logic          rsp_valid, rsp_ready;

  bypass_rf_operand_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_WIDTH(TW)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_addr_1(req_addr_1), .i_req_addr_2(req_addr_2),
    .i_req_use_2(req_use_2), .i_req_tag(req_tag),
    .o_addr_1(o_addr_1), .o_addr_2(o_addr_2),
    .o_rrese_1(o_rrese_1), .o_rrese_2(o_rrese_2),
    .i_rres_ready_1(rres_ready_1), .i_rres_ready_2(rres_ready_2),
    .i_rname_1(rname_1), .i_rname_2(rname_2),
    .o_valid_name_1(o_valid_name_1), .o_valid_name_2(o_valid_name_2),
    .i_valid_in_1(valid_in_1), .i_valid_in_2(valid_in_2),
    .o_name_1(o_name_1), .o_name_2(o_name_2),
    .i_d_in_1(d_in_1), .i_d_in_2(d_in_2),
    .o_rd_f_1(o_rd_f_1), .o_rd_f_2(o_rd_f_2),
    .o_fe_1(o_fe_1), .o_fe_2(o_fe_2),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_op_1(rsp_op_1), .o_rsp_op_2(rsp_op_2), .o_rsp_tag(rsp_tag)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Register file contents and stimulus knobs (percent probabilities).
  logic [DW-1:0] rf [32];
  int unsigned p_req, p_grant, p_valid, p_rsp;
  bit            fix_req, fx_use2;
  logic [AW-1:0] fx_a1, fx_a2;

  // Transaction-level reference state.
  bit            in_flight, g1, g2, c1, c2, use2, free_pend, fuse2;
  logic [AW-1:0] a1, a2, ra1, ra2;
  logic [TW-1:0] tag_m;
  slot_name_t    n1, n2, fn1, fn2;
  logic [DW-1:0] eop1, eop2;
  int            n_acc, n_hs;

  task automatic model_clear();
    in_flight = 0; free_pend = 0; g1 = 0; g2 = 0; c1 = 0; c2 = 0;
    use2 = 0; fuse2 = 0; ra1 = '0; ra2 = '0;
  endtask

  task automatic drive();
    req_valid = ($urandom_range(99) < p_req);
    if (fix_req) begin
      req_addr_1 = fx_a1; req_addr_2 = fx_a2; req_use_2 = fx_use2;
    end else begin
      req_addr_1 = AW'($urandom); req_addr_2 = AW'($urandom);
      req_use_2  = ($urandom_range(3) != 0);
    end
    req_tag      = TW'($urandom);
    rres_ready_1 = ($urandom_range(99) < p_grant);
    rres_ready_2 = ($urandom_range(99) < p_grant);
    rname_1      = slot_name_t'($urandom);
    rname_2      = slot_name_t'($urandom);
    valid_in_1   = ($urandom_range(99) < p_valid);
    valid_in_2   = ($urandom_range(99) < p_valid);
    d_in_1       = valid_in_1 ? rf[ra1] : $urandom;
    d_in_2       = valid_in_2 ? rf[ra2] : $urandom;
    rsp_ready    = ($urandom_range(99) < p_rsp);
  endtask

  task automatic monitor();
    bit exp_rdy, exp_rr1, exp_rr2, wait_ph, exp_rsp, exp_fe2;
    exp_rdy = !in_flight;
    exp_rr1 = in_flight && !g1;
    exp_rr2 = in_flight && !g2;
    wait_ph = in_flight && g1 && g2 && !(c1 && c2);
    exp_rsp = in_flight && c1 && c2;
    exp_fe2 = free_pend && fuse2;

    check("req_ready", 64'(req_ready), 64'(exp_rdy));
    check("rrese_1", 64'(o_rrese_1), 64'(exp_rr1));
    check("rrese_2", 64'(o_rrese_2), 64'(exp_rr2));
    if (exp_rr1) check("addr_1", 64'(o_addr_1), 64'(a1));
    if (exp_rr2) check("addr_2", 64'(o_addr_2), 64'(a2));
    check("valid_name_1", 64'(o_valid_name_1), 64'(wait_ph ? n1 : slot_name_t'(0)));
    check("valid_name_2", 64'(o_valid_name_2), 64'((wait_ph && use2) ? n2 : slot_name_t'(0)));
    check("name_1", 64'(o_name_1), 64'(wait_ph ? n1 : slot_name_t'(0)));
    check("name_2", 64'(o_name_2), 64'((wait_ph && use2) ? n2 : slot_name_t'(0)));
    check("rsp_valid", 64'(rsp_valid), 64'(exp_rsp));
    if (exp_rsp) begin
      check("rsp_op_1", 64'(rsp_op_1), 64'(eop1));
      check("rsp_op_2", 64'(rsp_op_2), 64'(eop2));
      check("rsp_tag", 64'(rsp_tag), 64'(tag_m));
    end
    check("fe_1", 64'(o_fe_1), 64'(free_pend));
    check("rd_f_1", 64'(o_rd_f_1), 64'(free_pend ? fn1 : slot_name_t'(0)));
    check("fe_2", 64'(o_fe_2), 64'(exp_fe2));
    check("rd_f_2", 64'(o_rd_f_2), 64'(exp_fe2 ? fn2 : slot_name_t'(0)));

    // Advance the reference to what the coming clock edge commits.
    free_pend = 0;
    if (exp_rr1 && rres_ready_1) begin g1 = 1; n1 = rname_1; ra1 = o_addr_1; end
    if (exp_rr2 && rres_ready_2) begin g2 = 1; n2 = rname_2; ra2 = o_addr_2; end
    if (wait_ph) begin
      if (!c1 && valid_in_1) begin c1 = 1; eop1 = rf[a1]; end
      if (!c2 && valid_in_2) begin c2 = 1; eop2 = rf[a2]; end
    end
    if (exp_rsp && rsp_ready) begin
      free_pend = 1; fn1 = n1; fn2 = n2; fuse2 = use2; in_flight = 0; n_hs++;
      rf[$urandom_range(31)] = $urandom;
    end
    if (exp_rdy && req_valid) begin
      in_flight = 1; a1 = req_addr_1; a2 = req_addr_2; use2 = req_use_2; tag_m = req_tag;
      g1 = 0; c1 = 0; g2 = !use2; c2 = !use2;
      if (!use2) eop2 = '0;
      n_acc++;
    end
  endtask

  task automatic step();
    @(negedge clk);
    drive();
    #4;
    monitor();
  endtask

  task automatic drain();
    int k = 0;
    p_req = 0; p_grant = 100; p_valid = 100; p_rsp = 100;
    while ((in_flight || free_pend) && k < 60) begin
      step();
      k++;
    end
    check("drain", 64'(in_flight || free_pend), 64'(0));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, 64'({req_ready, o_addr_1, o_addr_2, o_rrese_1, o_rrese_2,
                              o_valid_name_1, o_valid_name_2, o_name_1, o_name_2,
                              o_rd_f_1, o_rd_f_2, o_fe_1, o_fe_2, rsp_valid, rsp_tag}), 64'(0));
    check({tag, "_ops"}, {rsp_op_1, rsp_op_2}, 64'(0));
  endtask

  int unsigned phase_tbl [4][4] = '{'{60, 50, 40, 50}, '{80, 30, 80, 30},
                                    '{100, 90, 20, 90}, '{50, 100, 100, 100}};

  initial begin
    int acc0;
    int k;
    rst_n = 1'b0;
    req_valid = 0; req_addr_1 = '0; req_addr_2 = '0; req_use_2 = 0; req_tag = '0;
    rres_ready_1 = 0; rres_ready_2 = 0; rname_1 = '0; rname_2 = '0;
    valid_in_1 = 0; valid_in_2 = 0; d_in_1 = '0; d_in_2 = '0; rsp_ready = 0;
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    model_clear();
    n_acc = 0; n_hs = 0; fix_req = 0;

    @(posedge clk);
    #2;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);

    // Best case and back-to-back: fixed operands 3/7, everything answers at once.
    rf[3] = 32'h11; rf[7] = 32'h22;
    fix_req = 1; fx_a1 = 5'd3; fx_a2 = 5'd7; fx_use2 = 1;
    p_req = 100; p_grant = 100; p_valid = 100; p_rsp = 100;
    acc0 = n_acc;
    repeat (40) step();
    check("b2b_accepts", 64'(n_acc - acc0), 64'(10));
    fx_use2 = 0;
    repeat (12) step();
    fix_req = 0;

    for (int ph = 0; ph < 4; ph++) begin
      p_req = phase_tbl[ph][0]; p_grant = phase_tbl[ph][1];
      p_valid = phase_tbl[ph][2]; p_rsp = phase_tbl[ph][3];
      repeat (600) step();
    end

    // Asynchronous reset while waiting for data.
    drain();
    p_valid = 0; p_req = 100;
    step();
    p_req = 0;
    k = 0;
    while (!(in_flight && g1 && g2) && k < 20) begin
      step();
      k++;
    end
    check("reach_wait", 64'(in_flight && g1 && g2), 64'(1));
    step();
    step();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    model_clear();
    repeat (2) @(posedge clk);
    check_all_zero("held_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);

    p_req = 70; p_grant = 80; p_valid = 80; p_rsp = 80;
    repeat (300) step();
    drain();
    check("handshakes_seen", 64'(n_hs > 150), 64'(1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
